led_rx_decoder: RTL
===================

Name: led_rx_decoder

Overview:
- APB3 slave that receives the pulse-width-coded serial LED/IR line produced by the team's LED_RG transmitter.
- Measures each high pulse, classifies it as a short (0) or long (1) bit and accumulates per-frame statistics.
- A frame ends when the line stays low for a long gap; results are then latched for software, which collects them over APB.
- Sits on the same APB bus as the transmitter, decoded at PADDR[11:8] == ADDR_SEL.

Parameters:
- ADDR_SEL, 8: PADDR[11:8] value that selects this block.
- THRESH, 31: high width (cycles) at or above which a pulse decodes as 1.
- MIN_HIGH, 8: pulses shorter than this are glitches.
- MAX_HIGH, 52: pulses longer than this are errors.
- END_GAP, 1000: low-time (cycles) that terminates a frame.

Ports:
- PCLK  in  1  clock.
- PRESET  in  1  reset; one clock, reset asynchronous and active-high.
- PSEL  in  1  peripheral select.
- PENABLE  in  1  access phase.
- PWRITE  in  1  write/read.
- PADDR  in  32  address; [11:8] select, [3:2] register.
- PWDATA  in  32  write data.
- PRDATA  out  32  read data.
- PREADY  out  1  tied 1.
- PSLVERR  out  1  tied 0.
- rx_in  in  1  asynchronous serial line.
- frame_irq  out  1  level; equals frame_valid.

Behaviour:
- Input path: rx_in passes through a 2-flop synchroniser to give rx_s. All widths are counted on rx_s; edge latency is 2 cycles.
- Counters: high_cnt and low_cnt are 16 bits and saturate. Each is set to 1 on the first cycle of its level and incremented on each following cycle of that level.
- FSM states: WAIT_IDLE, IDLE, HIGH, LOW. Reset state is WAIT_IDLE.
- WAIT_IDLE:
  - low_cnt counts while rx_s = 0 and clears on rx_s = 1.
  - When low_cnt == END_GAP, go to IDLE. Frames starting mid-stream are never decoded.
- IDLE: on rx_s = 1, clear the frame accumulators, set high_cnt = 1, go to HIGH.
- HIGH:
  - If high_cnt would exceed MAX_HIGH while rx_s is still 1: set pulse_err, discard the frame, go to WAIT_IDLE.
  - On rx_s = 0 with high_cnt < MIN_HIGH: set pulse_err, add no bit, go to LOW.
  - On rx_s = 0 otherwise: bit = (high_cnt >= THRESH). Shift bit into shreg[31:0] at LSB. bit_count++ (saturates at 0xFFFF). If bit = 1, one_count++ (saturates). If bit = 1 and this is the first 1 in the frame, first_one_idx = bit_count before increment. Then low_cnt = 1 and go to LOW.
- LOW:
  - On rx_s = 1: high_cnt = 1, go to HIGH.
  - When low_cnt == END_GAP: frame end. Latch shreg, bit_count, one_count and first_one_idx into read registers. If frame_valid is already set, also set overrun; the new frame overwrites the old. Set frame_valid, go to IDLE.
  - A frame with zero accepted bits (glitches only) does not latch and does not set frame_valid.
- first_one_idx: 0xFFFF if the frame has no 1 bit.
- Registers (PADDR[3:2]):
  - 0 STATUS: [0] frame_valid, [1] overrun, [2] pulse_err, [3] busy (state is HIGH or LOW). Write is W1C on bits [2:0].
  - 1 COUNTS: [15:0] bit_count, [31:16] one_count. Read-only.
  - 2 DATA: last 32 bits decoded, LSB = newest. Read-only.
  - 3 FIRST: [15:0] first_one_idx, upper bits zero. Read-only.
- Read: PRDATA is combinational from the selected register when PSEL && !PWRITE && select matches; otherwise 0.
- Write: takes effect on PSEL && PENABLE && PWRITE && select match.
- W1C vs frame end in the same cycle: the frame end wins, so frame_valid stays 1.
- Reset values: all registers, flags, counters, PRDATA and frame_irq are 0; FSM is in WAIT_IDLE.
- Reset mid-frame: the partial frame is lost and no flag is set.

Optional Feature:
- Macro: LED_RX_GLITCH_FILTER_EN.
- Defined: rx_s is replaced by a 3-tap majority of the last three synchroniser outputs. Edge latency becomes 4 cycles; measured widths are unchanged for pulses of 2 or more cycles, and single-cycle spikes are removed.
- Undefined: the raw 2-flop output is used and latency is 2 cycles.

Test Plan:
- Reset, hold rx_in low for 1000 cycles, then send one 62-cycle slot with 42 high -> after END_GAP, frame_valid = 1, COUNTS = 0x0001_0001, DATA = 0x1, FIRST = 0.
- Send 8 slots of 19 high / 43 low, then 4 slots of 42 high -> bit_count = 12, one_count = 4, FIRST = 8, DATA = 0x00F.
- Send a 60-cycle high pulse mid-frame -> pulse_err = 1, no frame latched, next frame decodes only after 1000 low cycles.
- Send a 3-cycle pulse between valid bits -> pulse_err = 1, bit_count excludes it. With LED_RX_GLITCH_FILTER_EN defined, a 1-cycle spike leaves pulse_err = 0.
- Send two frames without reading -> overrun = 1 and the registers hold the second frame. Write 0x7 to STATUS -> all flags clear and frame_irq = 0.
- Assert PRESET mid-frame, release, send a fresh frame after 1000 low cycles -> only the fresh frame is reported and no stale bits appear.

Source files
------------

// File: rtl/led_rx_decoder_if.sv
// APB3 bus bundle for led_rx_decoder; the master modport is used by the bus
// driver and the slave modport by the decoder.
interface led_rx_decoder_if;
   logic        PSEL;
   logic        PENABLE;
   logic        PWRITE;
   logic [31:0] PADDR;
   logic [31:0] PWDATA;
   logic [31:0] PRDATA;
   logic        PREADY;
   logic        PSLVERR;

   modport master (
      output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
      input  PRDATA, PREADY, PSLVERR
   );

   modport slave (
      input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
      output PRDATA, PREADY, PSLVERR
   );
endinterface

// File: rtl/led_rx_decoder.sv
// Pulse-width LED/IR line decoder with APB3 register access.
// Optional LED_RX_GLITCH_FILTER_EN: 3-tap majority filter on the synchronised line.
module led_rx_decoder #(
   parameter int unsigned ADDR_SEL = 8,
   parameter int unsigned THRESH   = 31,
   parameter int unsigned MIN_HIGH = 8,
   parameter int unsigned MAX_HIGH = 52,
   parameter int unsigned END_GAP  = 1000
) (
   input  logic              PCLK,
   input  logic              PRESET,
   led_rx_decoder_if.slave   apb,
   input  logic              rx_in,
   output logic              frame_irq
);

   localparam logic [3:0]  SEL_C    = 4'(ADDR_SEL);
   localparam logic [15:0] THRESH_C = 16'(THRESH);
   localparam logic [15:0] MIN_C    = 16'(MIN_HIGH);
   localparam logic [15:0] MAX_C    = 16'(MAX_HIGH);
   localparam logic [15:0] GAP_C    = 16'(END_GAP);

   typedef enum logic [1:0] {WAIT_IDLE, IDLE, HIGH, LOW} state_t;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   logic sync1, sync2, rx_s;

   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= rx_in;
         sync2 <= sync1;
      end
   end

`ifdef LED_RX_GLITCH_FILTER_EN
   logic tap1, tap2, maj;

   // Registered majority: adds two cycles of latency but keeps widths of pulses >= 2 cycles.
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         tap1 <= 1'b0;
         tap2 <= 1'b0;
         maj  <= 1'b0;
      end else begin
         tap1 <= sync2;
         tap2 <= tap1;
         maj  <= (sync2 & tap1) | (sync2 & tap2) | (tap1 & tap2);
      end
   end

   assign rx_s = maj;
`else
   assign rx_s = sync2;
`endif

   state_t      state;
   logic [15:0] high_cnt, low_cnt;
   logic [31:0] shreg;
   logic [15:0] bit_count, one_count, first_idx;
   logic [31:0] rd_data;
   logic [15:0] rd_bits, rd_ones, rd_first;
   logic        frame_valid, overrun, pulse_err;
   logic        bit_v, sel, wr_en;

   assign bit_v = (high_cnt >= THRESH_C);
   assign sel   = (apb.PADDR[11:8] == SEL_C);
   assign wr_en = apb.PSEL && apb.PENABLE && apb.PWRITE && sel;

   // Flag clears are written first so that set conditions later in the block take priority.
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         state       <= WAIT_IDLE;
         high_cnt    <= '0;
         low_cnt     <= '0;
         shreg       <= '0;
         bit_count   <= '0;
         one_count   <= '0;
         first_idx   <= '0;
         rd_data     <= '0;
         rd_bits     <= '0;
         rd_ones     <= '0;
         rd_first    <= '0;
         frame_valid <= 1'b0;
         overrun     <= 1'b0;
         pulse_err   <= 1'b0;
      end else begin
         if (wr_en && apb.PADDR[3:2] == 2'd0) begin
            if (apb.PWDATA[0]) frame_valid <= 1'b0;
            if (apb.PWDATA[1]) overrun     <= 1'b0;
            if (apb.PWDATA[2]) pulse_err   <= 1'b0;
         end
         case (state)
            WAIT_IDLE: begin
               if (rx_s)                  low_cnt <= '0;
               else if (low_cnt == GAP_C) state   <= IDLE;
               else                       low_cnt <= sat_inc(low_cnt);
            end
            IDLE: begin
               if (rx_s) begin
                  shreg     <= '0;
                  bit_count <= '0;
                  one_count <= '0;
                  first_idx <= '1;
                  high_cnt  <= 16'd1;
                  state     <= HIGH;
               end
            end
            HIGH: begin
               if (rx_s) begin
                  if (high_cnt >= MAX_C) begin
                     pulse_err <= 1'b1;
                     low_cnt   <= '0;
                     state     <= WAIT_IDLE;
                  end else begin
                     high_cnt <= sat_inc(high_cnt);
                  end
               end else begin
                  low_cnt <= 16'd1;
                  state   <= LOW;
                  if (high_cnt < MIN_C) begin
                     pulse_err <= 1'b1;
                  end else begin
                     shreg     <= {shreg[30:0], bit_v};
                     bit_count <= sat_inc(bit_count);
                     if (bit_v) begin
                        one_count <= sat_inc(one_count);
                        if (one_count == '0) first_idx <= bit_count;
                     end
                  end
               end
            end
            LOW: begin
               if (rx_s) begin
                  high_cnt <= 16'd1;
                  state    <= HIGH;
               end else if (low_cnt == GAP_C) begin
                  state <= IDLE;
                  if (bit_count != '0) begin
                     rd_data     <= shreg;
                     rd_bits     <= bit_count;
                     rd_ones     <= one_count;
                     rd_first    <= first_idx;
                     frame_valid <= 1'b1;
                     if (frame_valid) overrun <= 1'b1;
                  end
               end else begin
                  low_cnt <= sat_inc(low_cnt);
               end
            end
            default: state <= WAIT_IDLE;
         endcase
      end
   end

   logic [31:0] prdata;

   always_comb begin
      prdata = '0;
      if (apb.PSEL && !apb.PWRITE && sel) begin
         case (apb.PADDR[3:2])
            2'd0:    prdata = {28'd0, (state == HIGH || state == LOW), pulse_err, overrun, frame_valid};
            2'd1:    prdata = {rd_ones, rd_bits};
            2'd2:    prdata = rd_data;
            default: prdata = {16'd0, rd_first};
         endcase
      end
   end

   assign apb.PRDATA  = prdata;
   assign apb.PREADY  = 1'b1;
   assign apb.PSLVERR = 1'b0;
   assign frame_irq   = frame_valid;

   logic unused_bits;
   assign unused_bits = ^{apb.PADDR[31:12], apb.PADDR[7:4], apb.PADDR[1:0], apb.PWDATA[31:3]};

endmodule
